qeciphy_serdes_ctrl: RTL and testbench
======================================

// Module: qeciphy_serdes_ctrl
//
// PURPOSE
// - Link bring-up sequencer for the QECIPHY SERDES: drives the GT reset and the TX/RX datapath resets.
// - Supervises GT power-good, GT reset-done and RX word alignment.
// - Runs the sequence: GT reset -> GT ready -> datapath release -> alignment -> link up.
// - Adds timeouts, bounded retries and link-loss recovery.
// - Runs in the free-running fabric clock domain, beside the SERDES.
//
// PARAMETERS
// - GT_RST_CYCLES   default 16      clk_i cycles gt_rst_n_o is held low per attempt (>=1)
// - TIMEOUT_CYCLES  default 1000000 max cycles in WAIT_GT or WAIT_ALIGN before the attempt fails (>=2)
// - BACKOFF_CYCLES  default 1024    cycles all resets are held asserted between attempts (>=1)
// - MAX_RETRIES     default 7       failed attempts tolerated before FAULT (>=1)
// - DROP_FILTER     default 8       consecutive bad-status cycles in LINK_UP that count as link loss (>=1)
//
// PORTS
// - clk_i                  in   1   free-running fabric clock
// - rst_i                  in   1   asynchronous, active-high reset
// - enable_i               in   1   level; high = bring link up, low = hold link down
// - restart_i              in   1   single-cycle pulse; clears FAULT / restarts the sequence
// - gt_power_good_i        in   1   GT power good (async; synchronised internally)
// - gt_tx_rst_done_i       in   1   GT TX reset done (async; synchronised internally)
// - gt_rx_rst_done_i       in   1   GT RX reset done (async; synchronised internally)
// - rx_datapath_aligned_i  in   1   RX word alignment done (async; synchronised internally)
// - gt_rst_n_o             out  1   GT reset, active-low
// - tx_datapath_rst_n_o    out  1   TX datapath reset, active-low
// - rx_datapath_rst_n_o    out  1   RX datapath reset, active-low
// - link_up_o              out  1   high only in LINK_UP
// - fault_o                out  1   high only in FAULT
// - state_o                out  3   current state encoding
// - retry_cnt_o            out  $clog2(MAX_RETRIES+1)   failed attempts since the last IDLE/LINK_UP
//
// BEHAVIOUR
// Reset and register rules
// - On rst_i: every output is 0. gt_rst_n_o and both datapath resets are therefore asserted; state is IDLE.
// - Each async input passes through a 2-flop synchroniser. An input edge at cycle t moves the FSM on the clk_i edge ending cycle t+2.
// - All outputs are registered and decoded from next-state, so they change on the same edge as state_o.
//
// State encodings
// - IDLE=0, GT_RST=1, WAIT_GT=2, WAIT_ALIGN=3, LINK_UP=4, BACKOFF=5, FAULT=6.
//
// Timers
// - A single timer clears on every state entry.
// - "Expires after N" means the transition happens on the edge ending the Nth cycle spent in that state.
//
// Transitions
// - IDLE: all resets asserted; retry_cnt=0. enable_i=1 -> GT_RST.
// - GT_RST: gt_rst_n_o=0. Expires after GT_RST_CYCLES -> WAIT_GT; gt_rst_n_o rises on that edge.
// - WAIT_GT: datapath resets asserted.
//   - pwr_good & tx_done & rx_done (synced) -> WAIT_ALIGN; tx/rx_datapath_rst_n_o rise on that edge.
//   - TIMEOUT_CYCLES expiry -> fail.
// - WAIT_ALIGN: aligned (synced) -> LINK_UP; retry_cnt cleared. TIMEOUT_CYCLES expiry -> fail.
// - LINK_UP: link_up_o=1.
//   - Bad status = aligned | pwr_good | tx_done | rx_done is low.
//   - Bad status for DROP_FILTER consecutive cycles -> fail.
//   - Any good cycle resets the filter count.
// - fail: if retry_cnt==MAX_RETRIES -> FAULT; otherwise retry_cnt+1 -> BACKOFF.
// - BACKOFF: all resets asserted. Expires after BACKOFF_CYCLES -> GT_RST.
// - FAULT: all resets asserted; fault_o=1; retry_cnt holds. restart_i -> IDLE.
//
// Priorities
// - enable_i=0 in any state -> IDLE next edge; this overrides everything.
// - restart_i outside FAULT -> IDLE.
// - enable_i=0 together with restart_i -> IDLE.
// - restart_i together with a timeout -> IDLE (restart wins).
//
// Other rules
// - retry_cnt saturates at MAX_RETRIES and never wraps.
// - The timer is wide enough for max(GT_RST_CYCLES, TIMEOUT_CYCLES, BACKOFF_CYCLES) and never wraps.
// - Datapath resets are never released while gt_rst_n_o=0.
//
// CONFIGURATION
// - Macro QECIPHY_SERDES_CTRL_STATS_EN defined:
//   - Adds output link_drop_cnt_o [15:0], reset 0.
//   - Increments on each LINK_UP->fail transition and saturates at 16'hFFFF.
//   - Clears only on rst_i.
// - Macro not defined: the port and counter do not exist.
//
// TESTING
// Bench parameters: GT_RST_CYCLES=4, TIMEOUT_CYCLES=64, BACKOFF_CYCLES=8, MAX_RETRIES=2, DROP_FILTER=4.
// - Clean bring-up:
//   - Stimulus: enable_i=1; GT status inputs high 10 cycles after gt_rst_n_o rises; aligned 20 cycles later.
//   - Response: gt_rst_n_o low for exactly 4 cycles; datapath resets rise 3 edges after the last status input rises; link_up_o=1 3 edges after aligned; retry_cnt_o=0.
// - Align timeout -> FAULT:
//   - Stimulus: GT status good, aligned never asserts.
//   - Response: WAIT_ALIGN timeout after 64 cycles; retry_cnt_o 1 then 2; third timeout -> fault_o=1, state_o=6, all resets low.
//   - Then restart_i pulse -> state_o=0, retry_cnt_o=0.
// - Link-loss filter:
//   - Stimulus: in LINK_UP, drop aligned for 3 cycles.
//   - Response: link_up_o stays 1.
//   - Stimulus: then drop aligned for 4 cycles.
//   - Response: BACKOFF; link_up_o=0; all resets asserted for 8 cycles; retry_cnt_o=1; link_drop_cnt_o=1 when STATS_EN.
// - Disable mid-sequence:
//   - Stimulus: enable_i=0 in WAIT_GT, WAIT_ALIGN and LINK_UP.
//   - Response: IDLE next edge; all resets low; retry_cnt_o=0.
// - Async reset mid-operation:
//   - Stimulus: rst_i pulse between clk_i edges while in LINK_UP.
//   - Response: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/qeciphy_serdes_ctrl.sv
// QECIPHY SERDES link bring-up sequencer: GT reset, datapath release, alignment, recovery.
// Optional link-drop statistics counter enabled by QECIPHY_SERDES_CTRL_STATS_EN.
module qeciphy_serdes_ctrl #(
   parameter int GT_RST_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int BACKOFF_CYCLES = 1024,
   parameter int MAX_RETRIES    = 7,
   parameter int DROP_FILTER    = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               enable_i,
   input  logic                               restart_i,
   input  logic                               gt_power_good_i,
   input  logic                               gt_tx_rst_done_i,
   input  logic                               gt_rx_rst_done_i,
   input  logic                               rx_datapath_aligned_i,
   output logic                               gt_rst_n_o,
   output logic                               tx_datapath_rst_n_o,
   output logic                               rx_datapath_rst_n_o,
   output logic                               link_up_o,
   output logic                               fault_o,
   output logic [2:0]                         state_o,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt_o
`ifdef QECIPHY_SERDES_CTRL_STATS_EN
   ,
   output logic [15:0]                        link_drop_cnt_o
`endif
);

   localparam int RW    = $clog2(MAX_RETRIES + 1);
   localparam int TMAX0 = (GT_RST_CYCLES > TIMEOUT_CYCLES) ?
                          GT_RST_CYCLES : TIMEOUT_CYCLES;
   localparam int TMAX  = (TMAX0 > BACKOFF_CYCLES) ? TMAX0 : BACKOFF_CYCLES;
   localparam int TW    = $clog2(TMAX + 1);
   localparam int FW    = $clog2(DROP_FILTER + 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_GT_RST     = 3'd1,
      S_WAIT_GT    = 3'd2,
      S_WAIT_ALIGN = 3'd3,
      S_LINK_UP    = 3'd4,
      S_BACKOFF    = 3'd5,
      S_FAULT      = 3'd6
   } state_t;

   logic [3:0]    async_w;
   logic [3:0]    meta_q;
   logic [3:0]    sync_q;
   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [FW-1:0] filt_q, filt_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          gt_rst_n_q, gt_rst_n_d;
   logic          dp_rst_n_q, dp_rst_n_d;
   logic          link_up_q, link_up_d;
   logic          fault_q, fault_d;
   logic          gt_ok, aligned, fail, link_fail;

   assign async_w = {rx_datapath_aligned_i, gt_rx_rst_done_i,
                     gt_tx_rst_done_i, gt_power_good_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= async_w;
         sync_q <= meta_q;
      end
   end

   assign gt_ok   = &sync_q[2:0];
   assign aligned = sync_q[3];

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      filt_d    = '0;
      fail      = 1'b0;
      link_fail = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_GT_RST;
         end
         S_GT_RST: begin
            if (timer_q == TW'(GT_RST_CYCLES - 1)) state_d = S_WAIT_GT;
         end
         S_WAIT_GT: begin
            if (gt_ok) state_d = S_WAIT_ALIGN;
            else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) fail = 1'b1;
         end
         S_WAIT_ALIGN: begin
            if (aligned) begin
               state_d = S_LINK_UP;
               retry_d = '0;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               fail = 1'b1;
            end
         end
         S_LINK_UP: begin
            if (!(gt_ok && aligned)) begin
               if (filt_q == FW'(DROP_FILTER - 1)) begin
                  fail      = 1'b1;
                  link_fail = 1'b1;
               end else begin
                  filt_d = filt_q + 1'b1;
               end
            end
         end
         S_BACKOFF: begin
            if (timer_q == TW'(BACKOFF_CYCLES - 1)) state_d = S_GT_RST;
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (fail) begin
         if (retry_q == RW'(MAX_RETRIES)) begin
            state_d = S_FAULT;
         end else begin
            state_d = S_BACKOFF;
            retry_d = retry_q + 1'b1;
         end
      end
      // Disable and restart override every other decision, including timeouts.
      if (!enable_i || restart_i) begin
         state_d   = S_IDLE;
         link_fail = 1'b0;
      end
      if (state_d == S_IDLE) retry_d = '0;
      if (state_d != state_q) timer_d = '0;
      else if (timer_q == {TW{1'b1}}) timer_d = timer_q;
      else timer_d = timer_q + 1'b1;
      gt_rst_n_d = (state_d == S_WAIT_GT) || (state_d == S_WAIT_ALIGN) ||
                   (state_d == S_LINK_UP);
      dp_rst_n_d = (state_d == S_WAIT_ALIGN) || (state_d == S_LINK_UP);
      link_up_d  = (state_d == S_LINK_UP);
      fault_d    = (state_d == S_FAULT);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         filt_q     <= '0;
         retry_q    <= '0;
         gt_rst_n_q <= 1'b0;
         dp_rst_n_q <= 1'b0;
         link_up_q  <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         filt_q     <= filt_d;
         retry_q    <= retry_d;
         gt_rst_n_q <= gt_rst_n_d;
         dp_rst_n_q <= dp_rst_n_d;
         link_up_q  <= link_up_d;
         fault_q    <= fault_d;
      end
   end

`ifdef QECIPHY_SERDES_CTRL_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (link_fail && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) drop_cnt_q <= '0;
      else drop_cnt_q <= drop_cnt_d;
   end

   assign link_drop_cnt_o = drop_cnt_q;
`endif

   assign gt_rst_n_o          = gt_rst_n_q;
   assign tx_datapath_rst_n_o = dp_rst_n_q;
   assign rx_datapath_rst_n_o = dp_rst_n_q;
   assign link_up_o           = link_up_q;
   assign fault_o             = fault_q;
   assign state_o             = state_q;
   assign retry_cnt_o         = retry_q;

endmodule

// File: tb/tb_qeciphy_serdes_ctrl.sv
// Bench for qeciphy_serdes_ctrl: cycle model from the behavioural rules plus directed checks.
// Drop-counter checks follow QECIPHY_SERDES_CTRL_STATS_EN.
module tb_qeciphy_serdes_ctrl;

   localparam int GTR = 4;
   localparam int TO  = 64;
   localparam int BO  = 8;
   localparam int MR  = 2;
   localparam int DF  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       restart = 1'b0;
   logic       pg = 1'b0;
   logic       txd = 1'b0;
   logic       rxd = 1'b0;
   logic       al = 1'b0;
   logic       gt_rst_n, tx_rst_n, rx_rst_n, link_up, fault;
   logic [2:0] state;
   logic [1:0] retry;
`ifdef QECIPHY_SERDES_CTRL_STATS_EN
   logic [15:0] drops;
`endif

   int checks = 0;
   int errors = 0;

   qeciphy_serdes_ctrl #(
      .GT_RST_CYCLES(GTR), .TIMEOUT_CYCLES(TO), .BACKOFF_CYCLES(BO),
      .MAX_RETRIES(MR), .DROP_FILTER(DF)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .restart_i(restart),
      .gt_power_good_i(pg), .gt_tx_rst_done_i(txd), .gt_rx_rst_done_i(rxd),
      .rx_datapath_aligned_i(al),
      .gt_rst_n_o(gt_rst_n), .tx_datapath_rst_n_o(tx_rst_n),
      .rx_datapath_rst_n_o(rx_rst_n), .link_up_o(link_up), .fault_o(fault),
      .state_o(state), .retry_cnt_o(retry)
`ifdef QECIPHY_SERDES_CTRL_STATS_EN
      , .link_drop_cnt_o(drops)
`endif
   );

   always #5 clk = ~clk;

   // Model: state plus the cycle index it was entered at; inputs seen two cycles late.
   typedef struct {
      int         st;
      int         cyc;
      int         entry;
      int         retry;
      int         run;
      int         drops;
      logic [3:0] s1;
      logic [3:0] s2;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.st = 0; r.cyc = 0; r.entry = 0; r.retry = 0;
      r.run = 0; r.drops = 0; r.s1 = '0; r.s2 = '0;
      return r;
   endfunction

   function automatic model_t model_step(model_t c, logic e, logic r,
                                         logic [3:0] raw);
      model_t n = c;
      int el = c.cyc - c.entry + 1;
      int nxt = c.st;
      bit f = 0;
      bit good_gt = &c.s2[2:0];
      n.cyc = c.cyc + 1;
      n.s1 = raw;
      n.s2 = c.s1;
      n.run = 0;
      case (c.st)
         0: nxt = 1;
         1: if (el == GTR) nxt = 2;
         2: if (good_gt) nxt = 3; else if (el == TO) f = 1;
         3: if (c.s2[3]) begin nxt = 4; n.retry = 0; end
            else if (el == TO) f = 1;
         4: if (!(&c.s2)) begin
               n.run = c.run + 1;
               if (n.run == DF) f = 1;
            end
         5: if (el == BO) nxt = 1;
         default: ;
      endcase
      if (f) begin
         if (c.retry == MR) nxt = 6;
         else begin nxt = 5; n.retry = c.retry + 1; end
      end
      if (!e || r) nxt = 0;
      else if (f && c.st == 4 && c.drops < 65535) n.drops = c.drops + 1;
      if (nxt == 0) n.retry = 0;
      if (nxt != c.st) n.entry = n.cyc;
      n.st = nxt;
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= model_reset();
      else m <= model_step(m, en, restart, {al, rxd, txd, pg});
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired, state_o=%0d at %0t", nm, state, $time);
   endtask

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("m_state", int'(state), m.st);
         chk("m_gt_rst_n", int'(gt_rst_n), int'(m.st >= 2 && m.st <= 4));
         chk("m_tx_rst_n", int'(tx_rst_n), int'(m.st == 3 || m.st == 4));
         chk("m_rx_rst_n", int'(rx_rst_n), int'(m.st == 3 || m.st == 4));
         chk("m_link_up", int'(link_up), int'(m.st == 4));
         chk("m_fault", int'(fault), int'(m.st == 6));
         chk("m_retry", int'(retry), m.retry);
`ifdef QECIPHY_SERDES_CTRL_STATS_EN
         chk("m_drops", int'(drops), m.drops);
`endif
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input int s, input int budget, input string nm);
      int k = 0;
      while (int'(state) != s && k < budget) begin step(1); k++; end
      if (int'(state) != s) timeout_fail(nm);
   endtask

   task automatic dwell(input int s, input int budget, output int n);
      n = 0;
      while (int'(state) == s && n < budget) begin step(1); n++; end
   endtask

   task automatic edges_to_high(input int which, input int budget, output int n);
      n = 0;
      while (n < budget) begin
         step(1);
         n++;
         if ((which == 0 && tx_rst_n) || (which == 1 && link_up)) break;
      end
   endtask

   int n;

   initial begin : stim
      #1 rst = 1'b1;
      step(3);
      chk("rst_state", int'(state), 0);
      chk("rst_gt_rst_n", int'(gt_rst_n), 0);
      chk("rst_retry", int'(retry), 0);
      rst = 1'b0;
      step(2);

      // Clean bring-up
      en = 1'b1;
      wait_state(1, 5, "enter_gt_rst");
      dwell(1, 20, n);
      chk("gt_rst_low_cycles", n, 4);
      chk("gt_rst_n_rise", int'(gt_rst_n), 1);
      step(9);
      pg = 1'b1; txd = 1'b1; rxd = 1'b1;
      edges_to_high(0, 10, n);
      chk("dp_release_edges", n, 3);
      chk("rx_rst_n_release", int'(rx_rst_n), 1);
      step(19);
      al = 1'b1;
      edges_to_high(1, 10, n);
      chk("link_up_edges", n, 3);
      chk("link_retry", int'(retry), 0);

      // Link-loss filter: 3 bad cycles tolerated, 4 is a drop
      al = 1'b0;
      step(3);
      al = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("filter_hold", int'(link_up), 1);
      end
      al = 1'b0;
      step(4);
      al = 1'b1;
      wait_state(5, 6, "enter_backoff");
      chk("drop_link_up", int'(link_up), 0);
      chk("drop_retry", int'(retry), 1);
      chk("drop_gt_rst_n", int'(gt_rst_n), 0);
`ifdef QECIPHY_SERDES_CTRL_STATS_EN
      chk("drop_cnt", int'(drops), 1);
`endif
      dwell(5, 20, n);
      chk("backoff_cycles", n, 8);

      // Disable in WAIT_GT, WAIT_ALIGN, LINK_UP
      wait_state(2, 10, "enter_wait_gt");
      en = 1'b0;
      step(1);
      chk("dis_gt_state", int'(state), 0);
      chk("dis_gt_retry", int'(retry), 0);
      chk("dis_gt_rst_n", int'(gt_rst_n), 0);
      al = 1'b0;
      en = 1'b1;
      wait_state(3, 20, "enter_wait_align");
      en = 1'b0;
      step(1);
      chk("dis_al_state", int'(state), 0);
      chk("dis_al_tx_rst_n", int'(tx_rst_n), 0);
      al = 1'b1;
      en = 1'b1;
      wait_state(4, 20, "enter_link_up");
      en = 1'b0;
      step(1);
      chk("dis_lu_state", int'(state), 0);
      chk("dis_lu_link_up", int'(link_up), 0);
      chk("dis_lu_rx_rst_n", int'(rx_rst_n), 0);

      // Align timeout x3 -> FAULT
      al = 1'b0;
      step(3);
      en = 1'b1;
      wait_state(3, 20, "to1_wait_align");
      dwell(3, 100, n);
      chk("to1_align_cycles", n, 64);
      chk("to1_retry", int'(retry), 1);
      wait_state(3, 30, "to2_wait_align");
      dwell(3, 100, n);
      chk("to2_retry", int'(retry), 2);
      wait_state(3, 30, "to3_wait_align");
      wait_state(6, 80, "enter_fault");
      chk("fault_o", int'(fault), 1);
      chk("fault_state", int'(state), 6);
      chk("fault_gt_rst_n", int'(gt_rst_n), 0);
      chk("fault_tx_rst_n", int'(tx_rst_n), 0);
      chk("fault_retry", int'(retry), 2);
      step(5);
      chk("fault_hold", int'(state), 6);
      restart = 1'b1;
      step(1);
      restart = 1'b0;
      chk("restart_state", int'(state), 0);
      chk("restart_retry", int'(retry), 0);
      chk("restart_fault", int'(fault), 0);

      // Async reset while in LINK_UP
      al = 1'b1;
      wait_state(4, 40, "enter_link_up2");
      #2 rst = 1'b1;
      #1;
      chk("arst_link_up", int'(link_up), 0);
      chk("arst_gt_rst_n", int'(gt_rst_n), 0);
      chk("arst_state", int'(state), 0);
      chk("arst_tx_rst_n", int'(tx_rst_n), 0);
      #1 rst = 1'b0;
      step(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
